vpe_dot_sched: RTL and testbench

- Command-driven sequencer for one 8-lane int8 dot-product PE in the VPE.
- Per command: latches a 64-bit weight vector, then streams cmd_len 64-bit data beats from an upstream source into the PE.
- Collects the 8-bit PE results into an output FIFO and signals completion.
- The PE has no backpressure, so issue is gated by credits: a PE beat is issued only when a FIFO slot is already reserved for its result.

---
 rtl/vpe_dot_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_vpe_dot_sched.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpe_dot_sched.sv
// vpe_dot_sched
//   Command-driven sequencer for one 8-lane int8 dot-product PE.
//
//   A command carries a 64-bit weight vector and a beat count. The weight is
//   registered onto pe_weight and given one cycle (WLOAD) to settle into the
//   PE. Then cmd_len source beats are forwarded to the PE. Results come back
//   on pe_res/pe_res_v and are collected in a small FIFO for downstream.
//
//   The PE cannot be stalled. A beat is therefore issued only when a FIFO
//   slot is already reserved for its result. The resv counter tracks the
//   results in flight plus the results still sitting in the FIFO.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_v/cmd_rdy         command handshake (cmd_rdy only in IDLE)
//   cmd_len, cmd_weight   beat count and weight vector for the command
//   src_data/src_v/src_rdy  upstream data beats
//   pe_data/pe_data_v     registered beat to the PE
//   pe_weight             registered weight to the PE, held between commands
//   pe_res/pe_res_v       result from the PE (no backpressure)
//   out_data/out_v/out_rdy  head of the result FIFO, popped on out_v & out_rdy
//   busy                  state is not IDLE
//   done                  one-cycle pulse on command completion
//   err                   sticky: result arrived in IDLE/WLOAD or into a full FIFO
//
// PE_LAT is the nominal PE latency. It is informational only: the credit
// scheme keeps the block correct for any latency.

module vpe_dot_sched #(
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PE_LAT     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_v,
  output logic             cmd_rdy,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [63:0]      cmd_weight,
  input  logic [63:0]      src_data,
  input  logic             src_v,
  output logic             src_rdy,
  output logic [63:0]      pe_data,
  output logic             pe_data_v,
  output logic [63:0]      pe_weight,
  input  logic [7:0]       pe_res,
  input  logic             pe_res_v,
  output logic [7:0]       out_data,
  output logic             out_v,
  input  logic             out_rdy,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = AW + 1;

  // Elaboration-time sanity check on the configuration.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PE_LAT < 1) begin : g_param_check
    $error("vpe_dot_sched: FIFO_DEPTH must be a power of two >= 2 and PE_LAT >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued_q;
  logic [LEN_W-1:0] received_q;
  logic [LEN_W-1:0] issued_inc;
  logic [LEN_W-1:0] received_nxt;
  logic [RW-1:0]    resv_q;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [RW-1:0]    fifo_cnt;

  logic cmd_acc;
  logic src_acc;
  logic pop;
  logic fifo_full;
  logic res_early;
  logic wr_en;
  logic res_err;

  assign cmd_rdy   = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cmd_acc   = cmd_v & cmd_rdy;

  // Issue only when a FIFO slot is already reserved for this beat's result.
  assign src_rdy   = (state == STREAM) && (resv_q < RW'(FIFO_DEPTH)) && (issued_q < len_q);
  assign src_acc   = src_v & src_rdy;

  assign out_v     = (fifo_cnt != '0);
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_v & out_rdy;
  assign fifo_full = (fifo_cnt == RW'(FIFO_DEPTH));

  // A result cannot belong to the current command before any beat has been
  // issued, so results in IDLE or WLOAD are dropped and flagged. A write
  // into a full FIFO is legal only when the head is popped in the same cycle.
  assign res_early = (state == IDLE) || (state == WLOAD);
  assign wr_en     = pe_res_v & ~res_early & (~fifo_full | pop);
  assign res_err   = pe_res_v & (res_early | (fifo_full & ~pop));

  assign issued_inc   = issued_q + LEN_W'(1);
  assign received_nxt = received_q + LEN_W'(wr_en);

  // Next-state logic. DRAIN looks at the post-write received count, so
  // the last result and the transition to DONE happen in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_acc) state_nxt = WLOAD;
      end
      WLOAD: begin
        state_nxt = (len_q != '0) ? STREAM : DONE;
      end
      STREAM: begin
        if (src_acc && (issued_inc == len_q)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (received_nxt == len_q) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command bookkeeping, PE-side registers and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      pe_weight  <= '0;
      pe_data    <= '0;
      pe_data_v  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done      <= (state_nxt == DONE);
      pe_data_v <= src_acc;
      if (src_acc) begin
        pe_data <= src_data;
      end
      if (res_err) begin
        err <= 1'b1;
      end
      if (cmd_acc) begin
        len_q      <= cmd_len;
        pe_weight  <= cmd_weight;
        issued_q   <= '0;
        received_q <= '0;
      end else begin
        if (src_acc) begin
          issued_q <= issued_inc;
        end
        if (wr_en) begin
          received_q <= received_nxt;
        end
      end
    end
  end

  // Reservation counter: a slot is claimed when a beat is accepted and
  // released only when its result leaves the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_q <= '0;
    end else if (src_acc && !pop) begin
      resv_q <= resv_q + 1'b1;
    end else if (!src_acc && pop) begin
      resv_q <= resv_q - 1'b1;
    end
  end

  // Result FIFO. It keeps draining independently of the command state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        fifo_mem[wr_ptr] <= pe_res;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (!wr_en && pop) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vpe_dot_sched.sv
// tb_vpe_dot_sched
//   Self-checking bench for vpe_dot_sched. The bench acts as the command
//   issuer, the data source, the downstream consumer and the PE itself.
//   Its PE returns the low byte of the signed lane-wise dot product after
//   PE_LAT cycles. A behavioural model built from queues tracks the results
//   the DUT must hold and what it must show every cycle.

module tb_vpe_dot_sched;

  localparam int LEN_W      = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int PE_LAT     = 5;

  localparam int P_IDLE   = 0;
  localparam int P_WLOAD  = 1;
  localparam int P_STREAM = 2;
  localparam int P_DRAIN  = 3;
  localparam int P_DONE   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_v;
  logic             cmd_rdy;
  logic [LEN_W-1:0] cmd_len;
  logic [63:0]      cmd_weight;
  logic [63:0]      src_data;
  logic             src_v;
  logic             src_rdy;
  logic [63:0]      pe_data;
  logic             pe_data_v;
  logic [63:0]      pe_weight;
  logic [7:0]       pe_res;
  logic             pe_res_v;
  logic [7:0]       out_data;
  logic             out_v;
  logic             out_rdy;
  logic             busy;
  logic             done;
  logic             err;

  vpe_dot_sched #(
    .LEN_W(LEN_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PE_LAT(PE_LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_v(cmd_v),
    .cmd_rdy(cmd_rdy),
    .cmd_len(cmd_len),
    .cmd_weight(cmd_weight),
    .src_data(src_data),
    .src_v(src_v),
    .src_rdy(src_rdy),
    .pe_data(pe_data),
    .pe_data_v(pe_data_v),
    .pe_weight(pe_weight),
    .pe_res(pe_res),
    .pe_res_v(pe_res_v),
    .out_data(out_data),
    .out_v(out_v),
    .out_rdy(out_rdy),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Behavioural model of the sequencer
  int          m_phase;
  int          m_len;
  int          m_issued;
  int          m_received;
  int          m_resv;
  logic [63:0] m_pe_data;
  logic [63:0] m_pe_weight;
  bit          m_pe_data_v;
  bit          m_done;
  bit          m_err;
  logic [7:0]  m_fifo[$];

  // PE pipeline: result values and the cycle each one is due
  int          pe_due[$];
  logic [7:0]  pe_val[$];

  // Pending source beats
  logic [63:0] src_q[$];

  // Observation logs used by the directed checks
  logic [7:0]  popped[$];
  int          pv_cycles[$];
  int          done_cycles[$];

  function automatic logic [7:0] dot8(input logic [63:0] d, input logic [63:0] w);
    int  s;
    byte a;
    byte b;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      a = d[i*8 +: 8];
      b = w[i*8 +: 8];
      s += int'(a) * int'(b);
    end
    return s[7:0];
  endfunction

  function automatic bit exp_src_rdy();
    return (m_phase == P_STREAM) && (m_resv < FIFO_DEPTH) && (m_issued < m_len);
  endfunction

  task automatic modelReset();
    m_phase     = P_IDLE;
    m_len       = 0;
    m_issued    = 0;
    m_received  = 0;
    m_resv      = 0;
    m_pe_data   = '0;
    m_pe_weight = '0;
    m_pe_data_v = 1'b0;
    m_done      = 1'b0;
    m_err       = 1'b0;
    m_fifo.delete();
    pe_due.delete();
    pe_val.delete();
    src_q.delete();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clearLogs();
    popped.delete();
    pv_cycles.delete();
    done_cycles.delete();
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic checkOutput();
    chk("cmd_rdy", cmd_rdy, m_phase == P_IDLE);
    chk("busy", busy, m_phase != P_IDLE);
    chk("src_rdy", src_rdy, exp_src_rdy());
    chk("pe_data_v", pe_data_v, m_pe_data_v);
    chk("pe_data", pe_data, m_pe_data);
    chk("pe_weight", pe_weight, m_pe_weight);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("out_v", out_v, m_fifo.size() != 0);
    if (m_fifo.size() != 0) chk("out_data", out_data, m_fifo[0]);
    if (pe_data_v) pv_cycles.push_back(cyc);
    if (done) done_cycles.push_back(cyc);
  endtask

  // Drive one cycle of inputs, advance the model, then check at the next negedge.
  task automatic applyStimulus(input bit cmd_go, input logic [LEN_W-1:0] len,
                               input logic [63:0] w, input int src_pct,
                               input int rdy_pct, input bit spurious);
    bit   res_due;
    bit   pop;
    bit   acc;
    bit   wr;
    int   nxt;
    cmd_v      = cmd_go;
    cmd_len    = len;
    cmd_weight = w;
    src_v      = (src_q.size() > 0) && (int'($urandom_range(99)) < src_pct);
    src_data   = (src_q.size() > 0) ? src_q[0] : {$urandom, $urandom};
    out_rdy    = (int'($urandom_range(99)) < rdy_pct);
    res_due    = (pe_due.size() > 0) && (pe_due[0] == cyc);
    if (res_due) begin
      pe_res_v = 1'b1;
      pe_res   = pe_val[0];
    end else begin
      pe_res_v = spurious;
      pe_res   = 8'($urandom);
    end
    if (out_v && out_rdy) popped.push_back(out_data);

    pop = (m_fifo.size() != 0) && out_rdy;
    acc = exp_src_rdy() && src_v;
    wr  = 1'b0;
    if (pe_res_v) begin
      if (m_phase == P_IDLE || m_phase == P_WLOAD) m_err = 1'b1;
      else if (m_fifo.size() == FIFO_DEPTH && !pop) m_err = 1'b1;
      else wr = 1'b1;
    end
    if (pop) void'(m_fifo.pop_front());
    if (wr) begin
      m_fifo.push_back(pe_res);
      m_received++;
    end
    if (res_due) begin
      void'(pe_due.pop_front());
      void'(pe_val.pop_front());
    end
    m_resv      = m_resv + int'(acc) - int'(pop);
    m_pe_data_v = acc;
    if (acc) begin
      m_pe_data = src_data;
      pe_due.push_back(cyc + 1 + PE_LAT);
      pe_val.push_back(dot8(src_data, m_pe_weight));
      void'(src_q.pop_front());
    end
    nxt = m_phase;
    case (m_phase)
      P_IDLE: begin
        if (cmd_go) begin
          m_len       = int'(len);
          m_pe_weight = w;
          m_issued    = 0;
          m_received  = 0;
          nxt         = P_WLOAD;
        end
      end
      P_WLOAD: nxt = (m_len != 0) ? P_STREAM : P_DONE;
      P_STREAM: begin
        if (acc) begin
          m_issued++;
          if (m_issued == m_len) nxt = P_DRAIN;
        end
      end
      P_DRAIN: if (m_received == m_len) nxt = P_DONE;
      default: nxt = P_IDLE;
    endcase
    m_phase = nxt;
    m_done  = (nxt == P_DONE);

    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runCycles(input int n, input int src_pct, input int rdy_pct);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, src_pct, rdy_pct, 1'b0);
  endtask

  task automatic runUntilIdle(input int src_pct, input int rdy_pct, input bit poke, input string tag);
    int n;
    n = 0;
    while (m_phase != P_IDLE && n < 3000) begin
      applyStimulus(poke && ($urandom_range(1) == 1), LEN_W'($urandom), {$urandom, $urandom},
                    src_pct, rdy_pct, 1'b0);
      n++;
    end
    if (m_phase != P_IDLE) begin
      n_checks++;
      $display("[TB] FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
    end
  endtask

  task automatic fillSource(input int n);
    for (int i = 0; i < n; i++) src_q.push_back({$urandom, $urandom});
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          t0;
    int          n;
    logic [63:0] w;
    logic [63:0] w2;
    logic [7:0]  basic_exp [4];

    rst_n      = 1'b0;
    cmd_v      = 1'b0;
    cmd_len    = '0;
    cmd_weight = '0;
    src_data   = '0;
    src_v      = 1'b0;
    pe_res     = '0;
    pe_res_v   = 1'b0;
    out_rdy    = 1'b0;
    modelReset();

    // Pin the PE arithmetic used by the model.
    chk("dot8_neg", dot8(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0002), 64'hFE);
    chk("dot8_all", dot8(64'h0202_0202_0202_0202, 64'h0303_0303_0303_0303), 64'h30);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput();
    chk("reset_cmd_rdy", cmd_rdy, 1);
    chk("reset_busy", busy, 0);
    chk("reset_src_rdy", src_rdy, 0);
    chk("reset_out_v", out_v, 0);
    chk("reset_err", err, 0);
    chk("reset_pe_weight", pe_weight, 0);
    rst_n = 1'b1;
    runCycles(2, 100, 100);

    // Basic stream: four beats whose results are 0x11..0x44
    $display("[TB] basic stream");
    clearLogs();
    basic_exp[0] = 8'h11; basic_exp[1] = 8'h22; basic_exp[2] = 8'h33; basic_exp[3] = 8'h44;
    src_q.push_back(64'h11); src_q.push_back(64'h22);
    src_q.push_back(64'h33); src_q.push_back(64'h44);
    t0 = cyc;
    applyStimulus(1'b1, 8'd4, 64'h0101_0101_0101_0101, 100, 100, 1'b0);
    runUntilIdle(100, 100, 1'b0, "basic");
    runCycles(3, 100, 100);
    chk("basic_pe_v_count", pv_cycles.size(), 4);
    if (pv_cycles.size() == 4) begin
      chk("basic_pe_v_first", pv_cycles[0], t0 + 3);
      chk("basic_pe_v_last", pv_cycles[3], t0 + 6);
    end
    chk("basic_done_count", done_cycles.size(), 1);
    if (done_cycles.size() == 1) chk("basic_done_cycle", done_cycles[0], t0 + 12);
    chk("basic_pop_count", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("basic_pop_value", popped[i], basic_exp[i]);
    chk("basic_err", err, 0);

    // Credit stall: downstream blocked, only FIFO_DEPTH beats may issue
    $display("[TB] credit stall");
    clearLogs();
    fillSource(12);
    applyStimulus(1'b1, 8'd12, {$urandom, $urandom}, 100, 0, 1'b0);
    runCycles(30, 100, 0);
    chk("stall_issued", pv_cycles.size(), 8);
    chk("stall_src_rdy", src_rdy, 0);
    chk("stall_out_v", out_v, 1);
    runCycles(3, 100, 100);
    runCycles(20, 100, 0);
    chk("stall_issued_after_3_pops", pv_cycles.size(), 11);
    runUntilIdle(100, 100, 1'b0, "stall");
    runCycles(10, 100, 100);
    chk("stall_pop_count", popped.size(), 12);
    chk("stall_err", err, 0);

    // Zero-length command
    $display("[TB] zero length");
    clearLogs();
    w  = {$urandom, $urandom};
    t0 = cyc;
    applyStimulus(1'b1, 8'd0, w, 100, 100, 1'b0);
    runUntilIdle(100, 100, 1'b0, "zero");
    runCycles(2, 100, 100);
    chk("zero_done_count", done_cycles.size(), 1);
    if (done_cycles.size() == 1) chk("zero_done_cycle", done_cycles[0], t0 + 2);
    chk("zero_pe_v_count", pv_cycles.size(), 0);
    chk("zero_pe_weight", pe_weight, w);

    // Busy command is ignored; next command limited by leftover FIFO entries
    $display("[TB] back to back");
    clearLogs();
    w  = {$urandom, $urandom};
    w2 = ~w;
    fillSource(3);
    applyStimulus(1'b1, 8'd3, w, 100, 0, 1'b0);
    applyStimulus(1'b1, 8'd9, w2, 100, 0, 1'b0);
    chk("b2b_cmd_rdy_stream", cmd_rdy, 0);
    applyStimulus(1'b1, 8'd9, w2, 100, 0, 1'b0);
    runUntilIdle(100, 0, 1'b1, "b2b_first");
    chk("b2b_first_issued", pv_cycles.size(), 3);
    chk("b2b_weight_kept", pe_weight, w);
    chk("b2b_fifo_held", out_v, 1);
    clearLogs();
    fillSource(10);
    applyStimulus(1'b1, 8'd10, w2, 100, 0, 1'b0);
    runCycles(30, 100, 0);
    chk("b2b_second_issued", pv_cycles.size(), 5);
    runUntilIdle(100, 100, 1'b0, "b2b_second");
    runCycles(12, 100, 100);
    chk("b2b_drained", out_v, 0);

    // Spurious PE result in IDLE
    $display("[TB] spurious result");
    clearLogs();
    applyStimulus(1'b0, '0, '0, 100, 100, 1'b1);
    chk("spur_err", err, 1);
    chk("spur_out_v", out_v, 0);
    runCycles(3, 100, 100);
    chk("spur_err_sticky", err, 1);
    fillSource(3);
    applyStimulus(1'b1, 8'd3, {$urandom, $urandom}, 100, 100, 1'b0);
    runUntilIdle(100, 100, 1'b0, "spur");
    runCycles(6, 100, 100);
    chk("spur_next_done", done_cycles.size(), 1);
    chk("spur_next_pops", popped.size(), 3);

    // Reset in the middle of streaming
    $display("[TB] reset mid-operation");
    fillSource(8);
    applyStimulus(1'b1, 8'd8, {$urandom, $urandom}, 100, 100, 1'b0);
    n = 0;
    while (m_issued < 3 && n < 50) begin
      applyStimulus(1'b0, '0, '0, 100, 100, 1'b0);
      n++;
    end
    chk("midrst_pe_data_v_before", pe_data_v, 1);
    cmd_v    = 1'b0;
    src_v    = 1'b0;
    pe_res_v = 1'b0;
    out_rdy  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pe_data_v", pe_data_v, 0);
    chk("midrst_pe_data", pe_data, 0);
    chk("midrst_pe_weight", pe_weight, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_out_v", out_v, 0);
    chk("midrst_cmd_rdy", cmd_rdy, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_src_rdy", src_rdy, 0);
    modelReset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
    runCycles(12, 100, 100);

    // Randomized commands with random source and sink throttling
    $display("[TB] random commands");
    for (int k = 0; k < 25; k++) begin
      int len;
      len = int'($urandom_range(20));
      fillSource(len);
      applyStimulus(1'b1, LEN_W'(len), {$urandom, $urandom}, 100, int'($urandom_range(20, 100)), 1'b0);
      runUntilIdle(int'($urandom_range(40, 100)), int'($urandom_range(20, 100)), 1'b1, "random");
    end
    runCycles(20, 100, 100);
    chk("final_err", err, 0);
    chk("final_out_v", out_v, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
